grid_update_ctrl: RTL

Sequencer that paces the snake game off the VGA frame rate and owns the write port of the 16x16 grid memory. Every TICK_FRAMES frames it requests one game step from the snake logic, waits for completion, then sweeps all 256 cells through the snake writer into grid memory, writing only during vertical blanking. It replaces the free-running slow clock: game state, renderer and memory all run on the one 25 MHz pixel clock.

---
 rtl/snake_pkg.sv | 19 +
 rtl/frame_divider.sv | 41 ++++
 rtl/grid_update_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared constants and types for the snake game grid sequencer.
// Cell codes are what the snake writer drives onto the grid memory data bus.
package snake_pkg;

    localparam int COORD_W = 4;
    localparam int DATA_W  = 2;

    localparam logic [DATA_W-1:0] CELL_EMPTY = 2'd0;
    localparam logic [DATA_W-1:0] CELL_SNAKE = 2'd1;
    localparam logic [DATA_W-1:0] CELL_FOOD  = 2'd2;
    localparam logic [DATA_W-1:0] CELL_WALL  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP  = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

endpackage

// File: rtl/frame_divider.sv
// Detects VGA frame starts (vsync falling edge) and divides them down to a
// single-cycle tick_due pulse, counting only while idle and not paused.
module frame_divider #(
    parameter int TICK_FRAMES = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_vsync,
    input  logic i_pause,
    input  logic i_idle,
    output logic o_tick_due
);

    logic       r_vsync_d1;
    logic       r_vsync_d2;
    logic [7:0] r_frame_cnt;
    logic       w_frame_start;
    logic       w_count_en;
    logic       w_last_frame;

    // Second stage is the "previous" sample, so the edge is seen one cycle after capture.
    assign w_frame_start = r_vsync_d2 & ~r_vsync_d1;
    assign w_count_en    = w_frame_start & i_idle & ~i_pause;
    assign w_last_frame  = (r_frame_cnt == 8'(TICK_FRAMES - 1));
    assign o_tick_due    = w_count_en & w_last_frame;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vsync_d1  <= 1'b1;
            r_vsync_d2  <= 1'b1;
            r_frame_cnt <= '0;
        end else begin
            r_vsync_d1 <= i_vsync;
            r_vsync_d2 <= r_vsync_d1;
            if (w_count_en) begin
                r_frame_cnt <= w_last_frame ? 8'd0 : r_frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/grid_update_ctrl.sv
// Paces snake game steps off the frame rate and sweeps the whole grid through
// the snake writer into grid memory, writing only during vertical blanking.
module grid_update_ctrl #(
    parameter int TICK_FRAMES = 8,
    parameter int COORD_W     = snake_pkg::COORD_W,
    parameter int DATA_W      = snake_pkg::DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vsync,
    input  logic               vblank,
    input  logic               pause,
    output logic               step_req,
    input  logic               step_ack,
    output logic [COORD_W-1:0] x_loc,
    output logic [COORD_W-1:0] y_loc,
    input  logic [DATA_W-1:0]  cell_in,
    output logic               wr_en,
    output logic [DATA_W-1:0]  wr_data,
    output logic               busy,
    output logic [15:0]        tick_count
);
    import snake_pkg::*;

    state_t             r_state;
    state_t             w_state_next;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_init_sweep;
    logic [15:0]        r_tick_count;
    logic               w_tick_due;
    logic               w_sweep_wr;
    logic               w_last_cell;

    frame_divider #(
        .TICK_FRAMES (TICK_FRAMES)
    ) u_frame_divider (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_vsync    (vsync),
        .i_pause    (pause),
        .i_idle     (r_state == ST_IDLE),
        .o_tick_due (w_tick_due)
    );

    assign w_last_cell = (&r_x) & (&r_y);

    always_comb begin
        w_state_next = r_state;
        step_req     = 1'b0;
        w_sweep_wr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick_due) w_state_next = ST_STEP;
            end
            ST_STEP: begin
                step_req = 1'b1;
                if (step_ack) w_state_next = ST_SWEEP;
            end
            ST_SWEEP: begin
                if (vblank) begin
                    w_sweep_wr = 1'b1;
                    if (w_last_cell) w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The reset state is SWEEP, so the strobe is masked while reset is held.
    assign wr_en      = w_sweep_wr & reset;
    assign wr_data    = wr_en ? cell_in : '0;
    assign busy       = (r_state != ST_IDLE);
    assign x_loc      = r_x;
    assign y_loc      = r_y;
    assign tick_count = r_tick_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_SWEEP;
            r_x          <= '0;
            r_y          <= '0;
            r_init_sweep <= 1'b1;
            r_tick_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_sweep_wr) begin
                if (w_last_cell) begin
                    r_x          <= '0;
                    r_y          <= '0;
                    r_init_sweep <= 1'b0;
                    if (!r_init_sweep) r_tick_count <= r_tick_count + 16'd1;
                end else begin
                    r_x <= r_x + COORD_W'(1);
                    if (&r_x) r_y <= r_y + COORD_W'(1);
                end
            end
        end
    end

endmodule
